// File: rtl/train_sequencer.sv
// Training-set sequencer: buffers samples for the Neuron datapath and replays them
// over the requestFlag/dataReady handshake, epoch by epoch, until done or the epoch limit.
module train_sequencer #(
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              loadEn,
   input  logic signed [6:0] loadX1,
   input  logic signed [6:0] loadX2,
   input  logic signed [1:0] loadT,
   input  logic              start,
   input  logic [15:0]       maxEpochs,
   input  logic              requestFlag,
   input  logic              neuronDone,
   output logic              neuronStart,
   output logic [31:0]       nOut,
   output logic signed [6:0] x1Out,
   output logic signed [6:0] x2Out,
   output logic signed [1:0] tOut,
   output logic              dataReady,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic              full,
   output logic              emptyErr,
   output logic [15:0]       epochCount
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_PRESENT,
      S_FINISH
   } state_t;

   localparam logic [AW:0] ONE        = (AW + 1)'(1);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   state_t         state_q, state_d;
   logic [AW:0]    count_q, count_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [15:0]    epoch_q, epoch_d;
   logic [15:0]    max_q, max_d;
   logic [15:0]    sample_q, sample_d;
   logic           timeout_q, timeout_d;
   logic           empty_err_q, empty_err_d;
   logic           wr_en;
   logic           last_sample;
   logic           full_int;
   logic [15:0]    epoch_inc;
   logic [15:0]    buffer_q [DEPTH];

   assign full_int    = (count_q == FULL_COUNT);
   assign last_sample = ({1'b0, idx_q} == (count_q - ONE));
   assign epoch_inc   = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      idx_d       = idx_q;
      epoch_d     = epoch_q;
      max_d       = max_q;
      sample_d    = sample_q;
      timeout_d   = timeout_q;
      empty_err_d = 1'b0;
      wr_en       = 1'b0;

      case (state_q)
         S_IDLE, S_FINISH: begin
            // start takes precedence over a same-cycle load, which is dropped
            if (start) begin
               if (count_q != '0) begin
                  idx_d     = '0;
                  epoch_d   = '0;
                  max_d     = maxEpochs;
                  timeout_d = 1'b0;
                  state_d   = S_WAIT;
               end else begin
                  empty_err_d = 1'b1;
               end
            end else if (loadEn && !full_int) begin
               wr_en   = 1'b1;
               count_d = count_q + ONE;
            end
         end
         S_WAIT: begin
            if (neuronDone) begin
               state_d = S_FINISH;
            end else if (requestFlag) begin
               sample_d = buffer_q[idx_q];
               state_d  = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (neuronDone) begin
               state_d = S_FINISH;
            end else if (!requestFlag) begin
               state_d = S_WAIT;
               if (last_sample) begin
                  idx_d   = '0;
                  epoch_d = epoch_inc;
                  if ((max_q != 16'd0) && (epoch_inc == max_q)) begin
                     state_d   = S_FINISH;
                     timeout_d = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         idx_q       <= '0;
         epoch_q     <= '0;
         max_q       <= '0;
         sample_q    <= '0;
         timeout_q   <= 1'b0;
         empty_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         epoch_q     <= epoch_d;
         max_q       <= max_d;
         sample_q    <= sample_d;
         timeout_q   <= timeout_d;
         empty_err_q <= empty_err_d;
      end
   end

   // Sample storage is deliberately not reset; a cleared count makes old entries unreachable.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buffer_q[count_q[AW-1:0]] <= {loadX1, loadX2, loadT};
      end
   end

   assign busy        = (state_q == S_WAIT) || (state_q == S_PRESENT);
   assign neuronStart = busy;
   assign dataReady   = (state_q == S_PRESENT);
   assign done        = (state_q == S_FINISH);
   assign timeout     = timeout_q;
   assign full        = full_int;
   assign emptyErr    = empty_err_q;
   assign epochCount  = epoch_q;
   assign nOut        = 32'(count_q);
   assign x1Out       = sample_q[15:9];
   assign x2Out       = sample_q[8:2];
   assign tOut        = sample_q[1:0];

endmodule

// File: tb/tb_train_sequencer.sv
// Scoreboard bench for train_sequencer: a dataset model predicts each presented sample,
// and a negedge monitor compares whatever the DUT presents against the expected queue.
module tb_train_sequencer;

   localparam int DEPTH = 512;
   localparam int AW    = 9;

   typedef struct packed {
      logic signed [6:0] x1;
      logic signed [6:0] x2;
      logic signed [1:0] t;
   } sample_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              loadEn;
   logic signed [6:0] loadX1;
   logic signed [6:0] loadX2;
   logic signed [1:0] loadT;
   logic              start;
   logic [15:0]       maxEpochs;
   logic              requestFlag;
   logic              neuronDone;
   logic              neuronStart;
   logic [31:0]       nOut;
   logic signed [6:0] x1Out;
   logic signed [6:0] x2Out;
   logic signed [1:0] tOut;
   logic              dataReady;
   logic              busy;
   logic              done;
   logic              timeout;
   logic              full;
   logic              emptyErr;
   logic [15:0]       epochCount;

   int checks   = 0;
   int failures = 0;

   sample_t ds[$];
   sample_t exp_q[$];
   int      m_pres;
   int      m_epoch;
   int      m_max;
   bit      m_finished;
   bit      m_timeout;

   always #5 clk = ~clk;

   train_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .loadEn(loadEn), .loadX1(loadX1), .loadX2(loadX2),
      .loadT(loadT), .start(start), .maxEpochs(maxEpochs), .requestFlag(requestFlag),
      .neuronDone(neuronDone), .neuronStart(neuronStart), .nOut(nOut), .x1Out(x1Out),
      .x2Out(x2Out), .tOut(tOut), .dataReady(dataReady), .busy(busy), .done(done),
      .timeout(timeout), .full(full), .emptyErr(emptyErr), .epochCount(epochCount)
   );

   function automatic void check(input string name, input logic signed [63:0] actual,
                                 input logic signed [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endfunction

   function automatic sample_t mk(input int a, input int b, input int c);
      sample_t s;
      s.x1 = 7'(a);
      s.x2 = 7'(b);
      s.t  = 2'(c);
      return s;
   endfunction

   function automatic sample_t rand_sample();
      return mk(int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 127)) - 64,
                int'($urandom_range(0, 3)) - 2);
   endfunction

   // Monitor: pops one expectation per rising dataReady and checks data stays put while high
   logic    prev_ready = 1'b0;
   sample_t cur;
   always @(negedge clk) begin
      if (dataReady && !prev_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_present: got dataReady=1 with no sample expected at %0t", $time);
         end else begin
            cur = exp_q.pop_front();
            check("x1Out", x1Out, cur.x1);
            check("x2Out", x2Out, cur.x2);
            check("tOut", tOut, cur.t);
         end
      end else if (dataReady) begin
         check("hold_stable", {x1Out, x2Out, tOut}, cur);
      end
      prev_ready = dataReady;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; loadEn = 1'b0; start = 1'b0; requestFlag = 1'b0; neuronDone = 1'b0;
      loadX1 = '0; loadX2 = '0; loadT = '0; maxEpochs = '0;
      tick();
      tick();
      rst = 1'b0;
      ds.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_neuronStart"}, neuronStart, 0);
      check({tag, "_nOut"}, nOut, 0);
      check({tag, "_x1Out"}, x1Out, 0);
      check({tag, "_x2Out"}, x2Out, 0);
      check({tag, "_tOut"}, tOut, 0);
      check({tag, "_dataReady"}, dataReady, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_full"}, full, 0);
      check({tag, "_emptyErr"}, emptyErr, 0);
      check({tag, "_epochCount"}, epochCount, 0);
   endtask

   task automatic load_sample(input sample_t s);
      loadX1 = s.x1; loadX2 = s.x2; loadT = s.t; loadEn = 1'b1;
      tick();
      loadEn = 1'b0;
      if (ds.size() < DEPTH) ds.push_back(s);
   endtask

   task automatic apply_stimulus_start(input int max_e);
      start = 1'b1;
      maxEpochs = 16'(max_e);
      tick();
      start = 1'b0;
      if (ds.size() > 0) begin
         m_pres = 0; m_epoch = 0; m_max = max_e; m_finished = 0; m_timeout = 0;
         check("start_busy", busy, 1);
         check("start_neuronStart", neuronStart, 1);
         check("start_nOut", nOut, ds.size());
         check("start_done", done, 0);
         check("start_timeout", timeout, 0);
         check("start_epochCount", epochCount, 0);
      end else begin
         check("emptyErr_pulse", emptyErr, 1);
         check("empty_busy", busy, 0);
         tick();
         check("emptyErr_clear", emptyErr, 0);
         check("empty_busy_after", busy, 0);
      end
   endtask

   // One full request/release handshake; loads issued while busy must be ignored
   task automatic apply_stimulus_handshake(input int hold, input int gap);
      int n;
      n = ds.size();
      exp_q.push_back(ds[m_pres % n]);
      requestFlag = 1'b1;
      loadEn = 1'($urandom_range(0, 1));
      loadX1 = 7'($urandom); loadX2 = 7'($urandom); loadT = 2'($urandom);
      tick();
      check("present_latency", dataReady, 1);
      if (!dataReady) exp_q.delete();
      check("busy_nOut", nOut, n);
      repeat (hold) tick();
      requestFlag = 1'b0;
      loadEn = 1'b0;
      tick();
      m_pres++;
      if (m_pres % n == 0) begin
         if (m_epoch < 65535) m_epoch++;
         if (m_max != 0 && m_epoch == m_max) begin
            m_finished = 1;
            m_timeout  = 1;
         end
      end
      check("release_dataReady", dataReady, 0);
      check("release_epochCount", epochCount, m_epoch);
      check("release_done", done, m_finished);
      check("release_timeout", timeout, m_timeout);
      check("release_busy", busy, !m_finished);
      repeat (gap) tick();
   endtask

   task automatic apply_stimulus_stop(input bit with_req);
      neuronDone = 1'b1;
      requestFlag = with_req;
      tick();
      neuronDone = 1'b0;
      requestFlag = 1'b0;
      m_finished = 1;
      m_timeout = 0;
      check("stop_done", done, 1);
      check("stop_timeout", timeout, 0);
      check("stop_busy", busy, 0);
      check("stop_neuronStart", neuronStart, 0);
      check("stop_dataReady", dataReady, 0);
      tick();
      check("finish_hold_done", done, 1);
      check("finish_hold_dataReady", dataReady, 0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      apply_reset();
      check_reset_values("reset");

      // Directed load/present and wrap-around over 7 handshakes
      load_sample(mk(5, -3, 1));
      load_sample(mk(-64, 63, -1));
      load_sample(mk(0, 1, 1));
      check("loaded_nOut", nOut, 3);
      apply_stimulus_start(0);
      for (int i = 0; i < 7; i++) apply_stimulus_handshake(i % 2, i % 3);
      check("wrap_epochCount", epochCount, 2);
      apply_stimulus_stop(1'b0);

      // Epoch limit of 2 over 3 samples
      apply_stimulus_start(2);
      guard = 0;
      while (!m_finished && guard < 20) begin
         apply_stimulus_handshake(0, 1);
         guard++;
      end
      check("timeout_handshakes", m_pres, 6);
      check("timeout_done", done, 1);
      check("timeout_flag", timeout, 1);
      check("timeout_epochCount", epochCount, 2);
      tick();
      check("timeout_hold", done, 1);

      // neuronDone and requestFlag together in WAIT
      apply_stimulus_start(0);
      apply_stimulus_stop(1'b1);
      tick();

      // Randomized runs, some continuing to load while in FINISH
      for (int r = 0; r < 25; r++) begin
         int k;
         int max_e;
         if (ds.size() > 10 || $urandom_range(0, 2) == 0) apply_reset();
         k = $urandom_range(0, 4);
         if (ds.size() == 0 && k == 0) k = 1;
         for (int j = 0; j < k; j++) begin
            load_sample(rand_sample());
            repeat ($urandom_range(0, 1)) tick();
         end
         check("rand_nOut", nOut, ds.size());
         max_e = $urandom_range(0, 3);
         apply_stimulus_start(max_e);
         if (max_e != 0) begin
            guard = 0;
            while (!m_finished && guard < 60) begin
               apply_stimulus_handshake($urandom_range(0, 2), $urandom_range(0, 2));
               guard++;
            end
            check("rand_timeout_done", done, 1);
            check("rand_timeout_flag", timeout, 1);
         end else begin
            int nh;
            nh = $urandom_range(0, 8);
            for (int j = 0; j < nh; j++)
               apply_stimulus_handshake($urandom_range(0, 2), $urandom_range(0, 2));
            apply_stimulus_stop(1'($urandom_range(0, 1)));
         end
      end

      // Full buffer: DEPTH+2 loads, extras dropped
      apply_reset();
      for (int i = 0; i < DEPTH + 2; i++) begin
         load_sample(rand_sample());
         if (i == DEPTH - 2) check("full_before", full, 0);
         if (i == DEPTH - 1) check("full_at_depth", full, 1);
      end
      check("full_final", full, 1);
      check("full_nOut", nOut, DEPTH);
      apply_stimulus_start(0);
      apply_stimulus_handshake(0, 0);
      apply_stimulus_handshake(1, 0);
      apply_stimulus_stop(1'b0);

      // Empty start after reset
      apply_reset();
      check_reset_values("reset2");
      apply_stimulus_start(0);

      // Reset while a sample is presented
      load_sample(mk(7, -7, -2));
      load_sample(mk(1, 2, 0));
      apply_stimulus_start(0);
      exp_q.push_back(ds[0]);
      requestFlag = 1'b1;
      tick();
      check("mid_present_ready", dataReady, 1);
      rst = 1'b1;
      requestFlag = 1'b0;
      tick();
      rst = 1'b0;
      ds.delete();
      check_reset_values("mid_reset");
      tick();

      check("scoreboard_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/train_sequencer.md
# train_sequencer

Controller that owns the training dataset for the `Neuron` perceptron datapath and sequences it through the neuron's `requestFlag`/`dataReady` handshake. Samples are loaded into an internal buffer, then replayed in order with wrap-around, epoch by epoch, until the neuron reports `done` or an epoch limit expires. It sits between the dataset loader and `Neuron`, replacing bench-side sample feeding.

## Interface

- `DEPTH`, 512, sample buffer capacity; a power of 2, at most 65536.
- `AW`, 9, buffer address width, log2(`DEPTH`).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `loadEn` in 1: write one sample this cycle.
- `loadX1`, `loadX2` in 7 signed: sample features.
- `loadT` in 2 signed: sample target.
- `start` in 1: begin a training run.
- `maxEpochs` in 16: epoch limit; 0 means unlimited. Sampled when `start` is accepted.
- `requestFlag` in 1: neuron requests a sample.
- `neuronDone` in 1: neuron has converged.
- `neuronStart` out 1: start signal driven to the neuron.
- `nOut` out 32: sample count, zero-extended, driven to the neuron's `nInput`.
- `x1Out`, `x2Out` out 7 signed: current sample features.
- `tOut` out 2 signed: current sample target.
- `dataReady` out 1: current sample is valid.
- `busy` out 1: a run is in progress.
- `done` out 1: run finished.
- `timeout` out 1: run ended on the epoch limit.
- `full` out 1: the buffer holds `DEPTH` samples.
- `emptyErr` out 1: one-cycle pulse when `start` is seen with zero samples loaded.
- `epochCount` out 16: number of completed epochs.

## Operation

- **States:**
  - IDLE: accepts loads and `start`.
  - WAIT: waits for `requestFlag`.
  - PRESENT: drives a sample with `dataReady` high.
  - FINISH: holds the result; accepts loads and `start`.
- **Loading** (IDLE or FINISH only):
  - `loadEn` writes `{loadX1, loadX2, loadT}` to buffer[`count`] and increments `count`.
  - Ignored when `full` is high, and in WAIT or PRESENT.
- **Start:**
  - `start` in IDLE or FINISH with `count` > 0: `idx`←0, `epochCount`←0, `maxEpochs` latched, `done`/`timeout` cleared, go to WAIT.
  - With `count` = 0: stay in the current state and pulse `emptyErr`.
  - `start` and `loadEn` in the same cycle: `start` wins and the load is dropped.
- **WAIT:**
  - `requestFlag` high: register buffer[`idx`] into `x1Out`/`x2Out`/`tOut`, set `dataReady`, go to PRESENT.
- **PRESENT:**
  - Hold data and `dataReady` while `requestFlag` is high.
  - When `requestFlag` is low: clear `dataReady` and go to WAIT.
  - Index advance: if `idx` = `count`−1, set `idx`←0 and increment `epochCount`; otherwise `idx`←`idx`+1.
- **Termination:**
  - `neuronDone` high in WAIT or PRESENT: go to FINISH, `done`=1, `dataReady`=0. Takes priority over `requestFlag` in the same cycle.
  - Epoch limit: if `maxEpochs` ≠ 0 and `epochCount` reaches `maxEpochs` on a wrap, go to FINISH with `done`=1 and `timeout`=1.
  - `epochCount` saturates at 65535 when unlimited.
- **Outputs by state:**
  - `neuronStart` = `busy` = 1 in WAIT and PRESENT.
  - `done` stays high throughout FINISH.
  - `nOut` = `count` at all times.
- **Reset** (any state, including mid-handshake):
  - Return to IDLE; `count`, `idx`, `epochCount` ← 0.
  - Buffer contents are not cleared but become unreachable.

## Timing

- **Reset values:** `neuronStart` 0, `nOut` 0, `x1Out`/`x2Out`/`tOut` 0, `dataReady` 0, `busy` 0, `done` 0, `timeout` 0, `full` 0, `emptyErr` 0, `epochCount` 0.
- **Start:** `start` sampled at edge k → `busy`/`neuronStart` high after edge k.
- **Presenting a sample:** `requestFlag` seen high in WAIT at edge k → data and `dataReady`=1 valid after edge k. Data is stable until `dataReady` falls.
- **Releasing a sample:** `requestFlag` seen low in PRESENT at edge m → `dataReady`=0 and `idx` advanced after edge m.
- **Next request:** the earliest next `dataReady` follows edge m+1.
- **Stop:** `neuronDone` at edge k → `done`=1 and `busy`=0 after edge k.
- **Loading:** `full` updates on the same edge that writes the `DEPTH`-th sample.
- **Error pulse:** `emptyErr` is high for exactly the cycle after the rejected `start`.

## Test plan

- **Load and present:** load 3 samples (x1=5,x2=−3,t=1), (−64,63,−1), (0,1,1), then `start`; hold `requestFlag` high → `dataReady` rises one cycle later with x1Out=5, x2Out=−3, tOut=1, and `nOut`=3.
- **Wrap-around:** run 7 handshakes with `count`=3 → samples presented in order 0,1,2,0,1,2,0; `epochCount` reads 1 after the 3rd release and 2 after the 6th.
- **Epoch timeout:** `maxEpochs`=2, `count`=3, `neuronDone` never asserted → FINISH after the 6th release with `done`=1, `timeout`=1, `epochCount`=2, `dataReady`=0.
- **Simultaneous `neuronDone` and `requestFlag` in WAIT** → `done`=1, `timeout`=0, and `dataReady` never rises.
- **Full buffer and empty start:**
  - Load `DEPTH`+2 samples → `full`=1 and `nOut`=`DEPTH`; the extra samples are dropped.
  - After `rst`, `start` with no samples → `emptyErr` pulses for 1 cycle and `busy` stays 0.
- **Reset mid-PRESENT:** assert `rst` with `dataReady` high → all outputs return to reset values on the next edge and `nOut`=0.
